serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 9 +
 rtl/full_subtractor_cell.sv | 12 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_pkg;
    localparam int WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit difference and borrow for a - b - borrow_in
// ports: a, b, borrow_in (in); d, borrow_out (out)
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic d,
    output logic borrow_out
);
    assign d          = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, one bit per clock
// ports: clk, rst_n (sync, active-low), start, a, b, borrow_in (in);
//        busy, done, d, borrow_out, overflow (out, only with SERIAL_SUB_OVF_EN)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, r;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             bit_d, bit_bo;
    logic             load, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif

    full_subtractor_cell u_cell (
        .a         (sa[0]),
        .b         (sb[0]),
        .borrow_in (br),
        .d         (bit_d),
        .borrow_out(bit_bo)
    );

    // start is honoured from IDLE and from DONE (back-to-back), never in RUN
    assign load = start && (state != RUN);
    assign last = (cnt == LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == RUN) ? (last ? DONE : RUN)
                                   : (start ? RUN : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            r          <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            d          <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= borrow_in;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= bit_bo;
            r   <= {bit_d, r[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            // the final bit is the result MSB, so publish straight from the cell
            if (last) begin
                d          <= {bit_d, r[WIDTH-1:1]};
                borrow_out <= bit_bo;
`ifdef SERIAL_SUB_OVF_EN
                overflow   <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench against an arithmetic model
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         borrow_in = 1'b0;
    logic         busy, done, borrow_out;
    logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge 0 is busy for W cycles, then the
    // result (plain wide arithmetic) appears together with done for one cycle.
    int           t = -1;
    logic [W-1:0] m_d = '0, p_d = '0;
    logic         m_bo = 1'b0, p_bo = 1'b0, m_ov = 1'b0, p_ov = 1'b0;

    always @(posedge clk) begin
        logic [W:0] full;
        if (!rst_n) begin
            t = -1; m_d = '0; m_bo = 1'b0; m_ov = 1'b0;
        end else if ((t < 0 || t == W) && start) begin
            t = 0;
            full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
            p_d  = full[W-1:0];
            p_bo = full[W];
            p_ov = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else if (t >= 0 && t < W) begin
            t++;
            if (t == W) begin
                m_d = p_d; m_bo = p_bo; m_ov = p_ov;
            end
        end else begin
            t = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, (t >= 0 && t < W)});
            check("done", {31'b0, done}, {31'b0, (t == W)});
            check("d", {24'b0, d}, {24'b0, m_d});
            check("borrow_out", {31'b0, borrow_out}, {31'b0, m_bo});
`ifdef SERIAL_SUB_OVF_EN
            check("overflow", {31'b0, overflow}, {31'b0, m_ov});
`endif
        end
    end

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                          output int lat, output int bcyc);
        int edges;
        @(negedge clk);
        a = aa; b = bb; borrow_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        edges = 1;
        bcyc = busy ? 1 : 0;
        while (!done && edges < 40) begin
            @(negedge clk);
            edges++;
            if (busy) bcyc++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        lat = edges;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bcyc, e1, edges;
        bit seen;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_d", {24'b0, d}, 32'd0);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, lat, bcyc);
        check("lit_05_03_d", {24'b0, d}, 32'h02);
        check("lit_05_03_bo", {31'b0, borrow_out}, 32'd0);
        check("latency", lat, 32'd9);
        check("busy_cycles", bcyc, 32'd8);

        run_op(8'h00, 8'h01, 1'b0, lat, bcyc);
        check("lit_00_01_d", {24'b0, d}, 32'hFF);
        check("lit_00_01_bo", {31'b0, borrow_out}, 32'd1);

        run_op(8'hFF, 8'hFF, 1'b1, lat, bcyc);
        check("lit_ff_ff_1_d", {24'b0, d}, 32'hFF);
        check("lit_ff_ff_1_bo", {31'b0, borrow_out}, 32'd1);

        run_op(8'h80, 8'h01, 1'b0, lat, bcyc);
        check("lit_80_01_d", {24'b0, d}, 32'h7F);
`ifdef SERIAL_SUB_OVF_EN
        check("lit_80_01_ov", {31'b0, overflow}, 32'd1);
`endif
        run_op(8'h10, 8'h01, 1'b0, lat, bcyc);
        check("lit_10_01_d", {24'b0, d}, 32'h0F);
`ifdef SERIAL_SUB_OVF_EN
        check("lit_10_01_ov", {31'b0, overflow}, 32'd0);
`endif

        // back-to-back with start held and operands churning during RUN
        @(negedge clk);
        a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
            if (!done) begin
                a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            end
        end while (!done && edges < 40);
        check("b2b_first_d", {24'b0, d}, 32'h02);
        e1 = edges;
        a = 8'h30; b = 8'h10; borrow_in = 1'b0;
        @(negedge clk);
        edges++;
        start = 1'b0;
        while (!done && edges < 80) begin
            @(negedge clk);
            edges++;
        end
        check("b2b_spacing", edges - e1, 32'd9);
        check("b2b_second_d", {24'b0, d}, 32'h20);

        // reset sampled at RUN edge 4
        @(negedge clk);
        a = 8'h9C; b = 8'h21; borrow_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_d", {24'b0, d}, 32'd0);
        check("abort_bo", {31'b0, borrow_out}, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", {31'b0, seen}, 32'd0);
        run_op(8'h40, 8'h01, 1'b1, lat, bcyc);
        check("after_abort_d", {24'b0, d}, 32'h3E);
        check("after_abort_lat", lat, 32'd9);

        for (int i = 0; i < 256; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), lat, bcyc);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
